// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, bubble encoding,
// FSM state encoding and the datapath select codes used between controller and datapath.
package if_stage_pkg;

    localparam int          ADDRESS_LEN = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } if_state_e;

    // Source for the next fetch address register.
    typedef enum logic {
        PC_SRC_BRANCH,
        PC_SRC_INC
    } pc_src_e;

    // Source for the outstanding-request address register.
    typedef enum logic [1:0] {
        REQ_SRC_PC,
        REQ_SRC_BRANCH,
        REQ_SRC_INC
    } req_src_e;

    // What the stage presents downstream this cycle.
    typedef enum logic [1:0] {
        INSTR_SEL_NOP,
        INSTR_SEL_HELD,
        INSTR_SEL_MEM
    } instr_sel_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: request/acknowledge FSM plus load enables and source selects
// for the fetch-stage datapath registers.
// Optional macro IF_ACK_BYPASS_EN: present returning memory data in the ack cycle.
module if_fetch_ctrl
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       branch_taken,
    input  logic       imem_ack,
    output logic       req_active,
    output logic       pc_ld,
    output pc_src_e    pc_src,
    output logic       req_ld,
    output req_src_e   req_src,
    output logic       instr_ld,
    output instr_sel_e instr_sel
);

    if_state_e state_q;
    if_state_e state_d;
    logic      bypass_hit;

    // Returning data that can go straight downstream instead of being captured.
`ifdef IF_ACK_BYPASS_EN
    assign bypass_hit = imem_ack && !freeze && !branch_taken;
`else
    assign bypass_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: a default before the case keeps this block free of inferred latches.
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    // A same-cycle redirect or a bypassed word keeps us requesting.
                    if (!branch_taken && !bypass_hit) state_d = S_VALID;
                end else if (branch_taken) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (imem_ack) state_d = S_REQ;
            S_VALID: if (branch_taken || !freeze) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath enables, selects and handshake outputs.
    always_comb begin
        req_active = 1'b0;
        pc_ld      = 1'b0;
        pc_src     = PC_SRC_INC;
        req_ld     = 1'b0;
        req_src    = REQ_SRC_PC;
        instr_ld   = 1'b0;
        instr_sel  = INSTR_SEL_NOP;
        case (state_q)
            S_IDLE: begin
                req_ld  = 1'b1;
                req_src = REQ_SRC_PC;
            end
            S_REQ: begin
                req_active = 1'b1;
                if (imem_ack && branch_taken) begin
                    // Data belongs to the wrong path; reissue at the target.
                    pc_ld   = 1'b1;
                    pc_src  = PC_SRC_BRANCH;
                    req_ld  = 1'b1;
                    req_src = REQ_SRC_BRANCH;
                end else if (imem_ack && bypass_hit) begin
                    instr_sel = INSTR_SEL_MEM;
                    pc_ld     = 1'b1;
                    pc_src    = PC_SRC_INC;
                    req_ld    = 1'b1;
                    req_src   = REQ_SRC_INC;
                end else if (imem_ack) begin
                    instr_ld = 1'b1;
                end else if (branch_taken) begin
                    // Request cannot be withdrawn; remember the target and drain.
                    pc_ld  = 1'b1;
                    pc_src = PC_SRC_BRANCH;
                end
            end
            S_DRAIN: begin
                req_active = 1'b1;
                if (branch_taken) begin
                    pc_ld  = 1'b1;
                    pc_src = PC_SRC_BRANCH;
                end
                if (imem_ack) begin
                    // Newest target wins, even when it lands with the ack.
                    req_ld  = 1'b1;
                    req_src = branch_taken ? REQ_SRC_BRANCH : REQ_SRC_PC;
                end
            end
            S_VALID: begin
                instr_sel = INSTR_SEL_HELD;
                if (branch_taken) begin
                    pc_ld   = 1'b1;
                    pc_src  = PC_SRC_BRANCH;
                    req_ld  = 1'b1;
                    req_src = REQ_SRC_BRANCH;
                end else if (!freeze) begin
                    pc_ld   = 1'b1;
                    pc_src  = PC_SRC_INC;
                    req_ld  = 1'b1;
                    req_src = REQ_SRC_INC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, fetch datapath and IF/ID presentation.
// Optional macro IF_ACK_BYPASS_EN: imem_rdata is presented in the cycle of its ack.
module if_stage #(
    parameter int                     ADDRESS_LEN = if_stage_pkg::ADDRESS_LEN,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   Branch_taken,
    input  logic [ADDRESS_LEN-1:0] Branch_Address,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic [ADDRESS_LEN-1:0] imem_rdata,
    input  logic                   imem_ack,
    output logic [ADDRESS_LEN-1:0] PC,
    output logic [ADDRESS_LEN-1:0] Instruction,
    output logic                   fetch_valid
);

    import if_stage_pkg::*;

    logic [ADDRESS_LEN-1:0] pc_q;
    logic [ADDRESS_LEN-1:0] req_addr_q;
    logic [ADDRESS_LEN-1:0] instr_q;
    logic [ADDRESS_LEN-1:0] pc_plus4;
    logic [ADDRESS_LEN-1:0] branch_target;

    logic       pc_ld;
    pc_src_e    pc_src;
    logic       req_ld;
    req_src_e   req_src;
    logic       instr_ld;
    instr_sel_e instr_sel;

    if_fetch_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (Branch_taken),
        .imem_ack     (imem_ack),
        .req_active   (imem_req),
        .pc_ld        (pc_ld),
        .pc_src       (pc_src),
        .req_ld       (req_ld),
        .req_src      (req_src),
        .instr_ld     (instr_ld),
        .instr_sel    (instr_sel)
    );

    // pc_q equals req_addr_q whenever a bypass increment happens, so one adder serves both.
    assign pc_plus4      = pc_q + ADDRESS_LEN'(4);
    assign branch_target = Branch_Address & ~ADDRESS_LEN'(3);

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= ADDRESS_LEN'(NOP_INSTR);
        end else begin
            if (pc_ld) pc_q <= (pc_src == PC_SRC_BRANCH) ? branch_target : pc_plus4;
            if (req_ld) begin
                case (req_src)
                    REQ_SRC_BRANCH: req_addr_q <= branch_target;
                    REQ_SRC_INC:    req_addr_q <= pc_plus4;
                    default:        req_addr_q <= pc_q;
                endcase
            end
            if (instr_ld) instr_q <= imem_rdata;
        end
    end

    assign imem_addr   = req_addr_q;
    assign PC          = pc_plus4;
    assign fetch_valid = (instr_sel != INSTR_SEL_NOP);

    // Presented instruction: held capture, bypassed memory word, or a bubble.
    always_comb begin
        Instruction = ADDRESS_LEN'(NOP_INSTR);
        case (instr_sel)
            INSTR_SEL_HELD: Instruction = instr_q;
`ifdef IF_ACK_BYPASS_EN
            INSTR_SEL_MEM:  Instruction = imem_rdata;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        fetch_valid;

    int checks   = 0;
    int failures = 0;

    if_stage #(.ADDRESS_LEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (Branch_taken),
        .Branch_Address (Branch_Address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ack       (imem_ack),
        .PC             (PC),
        .Instruction    (Instruction),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        fr;
        logic        br;
        logic [31:0] ba;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic fr, logic br, logic [31:0] ba, logic ack, logic [31:0] rd,
                                logic e_req, logic [31:0] e_addr, logic e_fv,
                                logic [31:0] e_ins, logic [31:0] e_pc);
        vec_t v;
        v.fr = fr; v.br = br; v.ba = ba; v.ack = ack; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv; v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    // Synthetic memory image.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_fv, input logic [31:0] e_ins, input logic [31:0] e_pc);
        check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, ".Instruction"}, Instruction, e_ins);
        check({tag, ".PC"}, PC, e_pc);
    endtask

    task automatic set_in(input logic fr, input logic br, input logic [31:0] ba,
                          input logic ack, input logic [31:0] rd);
        freeze         = fr;
        Branch_taken   = br;
        Branch_Address = ba;
        imem_ack       = ack;
        imem_rdata     = rd;
    endtask

    // Transaction-level model: one pending request (possibly stale), one presentation slot.
    bit          m_started, m_pend, m_stale, m_slot;
    logic [31:0] m_pend_addr, m_fetch_pc, m_slot_instr;

    task automatic model_reset();
        m_started = 0; m_pend = 0; m_stale = 0; m_slot = 0;
        m_pend_addr = 32'h0; m_fetch_pc = 32'h0; m_slot_instr = 32'h0;
    endtask

    function automatic bit model_bypass(logic fr, logic br, logic ack);
        bit b = 0;
`ifdef IF_ACK_BYPASS_EN
        b = m_pend && !m_stale && !m_slot && ack && !br && !fr;
`endif
        return b;
    endfunction

    task automatic model_step(input logic fr, input logic br, input logic [31:0] ba, input logic ack);
        logic [31:0] t;
        bit          byp;
        t   = ba & 32'hFFFF_FFFC;
        byp = model_bypass(fr, br, ack);
        if (!m_started) begin
            m_started = 1; m_pend = 1; m_stale = 0; m_pend_addr = m_fetch_pc;
        end else if (m_slot) begin
            if (br) begin
                m_slot = 0; m_fetch_pc = t; m_pend = 1; m_pend_addr = t;
            end else if (!fr) begin
                m_slot = 0; m_fetch_pc = m_fetch_pc + 4; m_pend = 1; m_pend_addr = m_fetch_pc;
            end
        end else if (m_pend) begin
            if (byp) begin
                m_fetch_pc = m_fetch_pc + 4; m_pend_addr = m_fetch_pc;
            end else begin
                if (br) m_fetch_pc = t;
                if (ack) begin
                    if (!m_stale && !br) begin
                        m_slot = 1; m_slot_instr = mem_word(m_pend_addr); m_pend = 0;
                    end else begin
                        m_pend_addr = m_fetch_pc; m_stale = 0;
                    end
                end else if (br) begin
                    m_stale = 1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 32'h0, 0, 32'h0);

        //        fr br ba            ack rd             req addr          fv ins            pc
        vecs[0]  = mk(0, 0, 32'h0,     0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4);
        vecs[1]  = mk(1, 0, 32'h0,     1, 32'hE3A01005, 1, 32'h0,        0, 32'h0,        32'h4);
        vecs[2]  = mk(0, 0, 32'h0,     0, 32'h0,        0, 32'h0,        1, 32'hE3A01005, 32'h4);
        vecs[3]  = mk(1, 0, 32'h0,     1, 32'h11111111, 1, 32'h4,        0, 32'h0,        32'h8);
        vecs[4]  = mk(1, 0, 32'h0,     0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8);
        vecs[5]  = mk(1, 0, 32'h0,     0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8);
        vecs[6]  = mk(1, 0, 32'h0,     0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8);
        vecs[7]  = mk(0, 0, 32'h0,     0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8);
        vecs[8]  = mk(0, 0, 32'h0,     0, 32'h0,        1, 32'h8,        0, 32'h0,        32'hC);
        vecs[9]  = mk(0, 1, 32'h100,   0, 32'h0,        1, 32'h8,        0, 32'h0,        32'hC);
        vecs[10] = mk(0, 0, 32'h0,     0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h104);
        vecs[11] = mk(0, 0, 32'h0,     1, 32'hDEADBEEF, 1, 32'h8,        0, 32'h0,        32'h104);
        vecs[12] = mk(0, 1, 32'h203,   1, 32'h22222222, 1, 32'h100,      0, 32'h0,        32'h104);
        vecs[13] = mk(1, 0, 32'h0,     1, 32'h33333333, 1, 32'h200,      0, 32'h0,        32'h204);
        vecs[14] = mk(1, 1, 32'h300,   0, 32'h0,        0, 32'h200,      1, 32'h33333333, 32'h204);
        vecs[15] = mk(0, 0, 32'h0,     0, 32'h0,        1, 32'h300,      0, 32'h0,        32'h304);
        vecs[16] = mk(1, 0, 32'h0,     1, 32'h44444444, 1, 32'h300,      0, 32'h0,        32'h304);
        vecs[17] = mk(0, 0, 32'h0,     0, 32'h0,        0, 32'h300,      1, 32'h44444444, 32'h304);
        vecs[18] = mk(0, 1, 32'h400,   0, 32'h0,        1, 32'h304,      0, 32'h0,        32'h308);
        vecs[19] = mk(0, 1, 32'h500,   1, 32'h55555555, 1, 32'h304,      0, 32'h0,        32'h404);
        vecs[20] = mk(1, 0, 32'h0,     1, 32'h66666666, 1, 32'h500,      0, 32'h0,        32'h504);
        vecs[21] = mk(0, 0, 32'h0,     0, 32'h0,        0, 32'h500,      1, 32'h66666666, 32'h504);
        vecs[22] = mk(0, 0, 32'h0,     0, 32'h0,        1, 32'h504,      0, 32'h0,        32'h508);

        repeat (3) @(negedge clk);
        #1 check_outs("reset", 0, 32'h0, 0, 32'h0, 32'h4);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: startup, freeze hold, drain, redirect corners.
        for (int i = 0; i < 23; i++) begin
            set_in(vecs[i].fr, vecs[i].br, vecs[i].ba, vecs[i].ack, vecs[i].rd);
            #1 check_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_fv, vecs[i].e_ins, vecs[i].e_pc);
            @(negedge clk);
        end

        // PC wrap at the top of the address space.
        set_in(1, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678);
        #1 check_outs("wrap0", 1, 32'h504, 0, 32'h0, 32'h508);
        @(negedge clk);
        set_in(1, 0, 32'h0, 1, 32'h7777_7777);
        #1 check_outs("wrap1", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        @(negedge clk);
        set_in(0, 0, 32'h0, 0, 32'h0);
        #1 check_outs("wrap2", 0, 32'h0, 1, 32'h7777_7777, 32'h0);
        @(negedge clk);
        #1 check_outs("wrap3", 1, 32'h0, 0, 32'h0, 32'h4);

        // Reset asserted in the middle of an outstanding request.
        #2 rst = 1'b1;
        #1 check_outs("midrst", 0, 32'h0, 0, 32'h0, 32'h4);
        @(negedge clk);
        rst = 1'b0;
        #1 check_outs("midrst_idle", 0, 32'h0, 0, 32'h0, 32'h4);
        @(negedge clk);
        #1 check_outs("midrst_req", 1, 32'h0, 0, 32'h0, 32'h4);

        // Randomized run against the transaction model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        begin
            int wait_cnt = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic        fr, br, ack, e_fv;
                logic [31:0] ba, rd, e_ins;
                bit          byp;
                fr  = ($urandom_range(0, 2) == 0);
                br  = m_started && ($urandom_range(0, 5) == 0);
                ba  = $urandom;
                ack = m_pend && (wait_cnt >= 5 || $urandom_range(0, 2) == 0);
                rd  = ack ? mem_word(imem_addr) : $urandom;
                set_in(fr, br, ba, ack, rd);
                byp   = model_bypass(fr, br, ack);
                e_fv  = m_slot || byp;
                e_ins = m_slot ? m_slot_instr : (byp ? mem_word(m_pend_addr) : 32'h0);
                #1 check_outs($sformatf("rnd%0d", cyc), m_pend, m_pend_addr, e_fv, e_ins,
                              m_fetch_pc + 32'h4);
                wait_cnt = (m_pend && !ack) ? wait_cnt + 1 : 0;
                model_step(fr, br, ba, ack);
                @(negedge clk);
            end
        end

`ifdef IF_ACK_BYPASS_EN
        // Back-to-back presentation with a single-cycle memory.
        set_in(0, 0, 32'h0, 0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check_outs("byp_idle", 0, 32'h0, 0, 32'h0, 32'h4);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            set_in(0, 0, 32'h0, 1, mem_word(imem_addr));
            #1 check_outs($sformatf("byp%0d", k), 1, 32'(4 * (k - 1)), 1,
                          mem_word(32'(4 * (k - 1))), 32'(4 * k));
            @(negedge clk);
        end
`endif

        set_in(0, 0, 32'h0, 0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
